// File: rtl/uart_pkg.sv
// uart_pkg: shared feeder state encoding and default data width
package uart_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    FEED_IDLE      = 2'd0,
    FEED_WAIT_BUSY = 2'd1,
    FEED_WAIT_DONE = 2'd2
  } feed_state_e;
endpackage

// File: rtl/tx_sync_fifo.sv
// tx_sync_fifo: circular-buffer FIFO with registered full and sticky overflow
import uart_pkg::*;
module tx_sync_fifo #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic full_q, full_d, ovf_q, ovf_d, push, pop;
  assign empty    = count_q == '0;
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign overflow = ovf_q;
  // full gates the push even when a pop happens on the same edge
  always_comb begin
    push     = wr_en && !full_q;
    pop      = rd_en && !empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + 1'b1 : (!push && pop) ? count_q - 1'b1 : count_q;
    full_d   = count_d == (AW+1)'(DEPTH);
    ovf_d    = ovf_q || (wr_en && full_q);
  end
  // pointer, count and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end
  // storage needs no reset; pointer reset discards the contents
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers words and hands them one at a time to the UART transmitter
import uart_pkg::*;
module uart_tx_feeder #(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   tx_busy,
  output logic [DATA_WIDTH-1:0]  p_data,
  output logic                   data_valid,
  output logic                   tx_err
);
  localparam int TW = BUSY_TIMEOUT > 1 ? $clog2(BUSY_TIMEOUT) : 1;
  feed_state_e state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d, rd_data;
  logic dv_q, dv_d, err_q, err_d, rd_en, empty;
  tx_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .count    (fifo_count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );
  assign p_data     = p_data_q;
  assign data_valid = dv_q;
  assign tx_err     = err_q;
  // pop in IDLE, wait for busy to rise (bounded), then wait for it to fall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_data_d = p_data_q;
    dv_d     = 1'b0;
    err_d    = err_q;
    rd_en    = 1'b0;
    case (state_q)
      FEED_IDLE: if (!empty) begin
        rd_en    = 1'b1;
        p_data_d = rd_data;
        dv_d     = 1'b1;
        cnt_d    = '0;
        state_d  = FEED_WAIT_BUSY;
      end
      FEED_WAIT_BUSY: if (tx_busy) state_d = FEED_WAIT_DONE;
        else if (cnt_q == TW'(BUSY_TIMEOUT-1)) begin
          err_d   = 1'b1;
          state_d = FEED_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      FEED_WAIT_DONE: state_d = tx_busy ? FEED_WAIT_DONE : FEED_IDLE;
      default: state_d = FEED_IDLE;
    endcase
  end
  // FSM, timeout counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FEED_IDLE;
      cnt_q    <= '0;
      p_data_q <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_data_q <= p_data_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed and randomized checks against a queue-based reference model
module tb_uart_tx_feeder;
  localparam int DEPTH = 8;
  localparam int RESP = 0, STALL = 1, TMO = 2;
  logic clk = 1'b0, reset = 1'b0, wr_en = 1'b0, tx_busy = 1'b0;
  logic [7:0] wr_data = '0;
  logic full, overflow, data_valid, tx_err;
  logic [3:0] fifo_count;
  logic [7:0] p_data;
  int checks = 0, failures = 0, cyc = 0;
  int mode = RESP, busy_left = 0, start_in = 0, err_at = -1, expect_dv_at = -1;
  logic [7:0] q[$];
  int dv_log[$];
  logic [7:0] exp_p = '0;
  logic exp_ovf = 1'b0, exp_err = 1'b0;

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_busy    (tx_busy),
    .p_data     (p_data),
    .data_valid (data_valid),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic we, input logic [7:0] wd);
    bit acc;
    logic prev;
    wr_en = we;
    wr_data = wd;
    @(posedge clk);
    #1;
    cyc++;
    acc = q.size() < DEPTH;
    if (we && !acc) exp_ovf = 1'b1;
    if (err_at == cyc) exp_err = 1'b1;
    if (data_valid) begin
      chk("pop_nonempty", q.size() != 0, 1);
      if (q.size() != 0) exp_p = q.pop_front();
      dv_log.push_back(cyc);
      if (mode == TMO) err_at = cyc + 4;
      if (mode == RESP) begin
        chk("dv_not_busy", tx_busy, 0);
        start_in = 2;
      end
    end
    if (expect_dv_at == cyc) chk("dv_after_fall", data_valid, 1);
    if (we && acc) q.push_back(wd);
    chk("fifo_count", fifo_count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, exp_ovf);
    chk("tx_err", tx_err, exp_err);
    chk("p_data", p_data, exp_p);
    prev = tx_busy;
    if (mode == STALL) tx_busy = 1'b1;
    else if (mode == TMO) tx_busy = 1'b0;
    else begin
      if (start_in > 0) begin
        start_in--;
        if (start_in == 0) busy_left = 11;
      end
      tx_busy = busy_left > 0;
      if (busy_left > 0) busy_left--;
    end
    if (prev && !tx_busy && q.size() != 0) expect_dv_at = cyc + 2;
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_p_data", p_data, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", tx_err, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    exp_p = '0;
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    err_at = -1;
    expect_dv_at = -1;
  endtask

  task automatic drain();
    int n = 0;
    while (!(q.size() == 0 && busy_left == 0 && start_in == 0 && !tx_busy) && n < 500) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("drain_bound", n < 500, 1);
    repeat (3) step(1'b0, 8'h00);
  endtask

  initial begin
    int n0, n;
    int pre;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    step(1'b1, 8'hA5);
    chk("lat_e0", data_valid, 0);
    step(1'b0, 8'h00);
    chk("lat_e1", data_valid, 1);
    chk("lat_data", p_data, 8'hA5);
    step(1'b0, 8'h00);
    chk("lat_e2", data_valid, 0);
    drain();

    n0 = dv_log.size();
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    drain();
    chk("pace_pulses", dv_log.size() - n0, 3);
    chk("pace_last", p_data, 8'h33);

    mode = STALL;
    step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    repeat (3) step(1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h80 + 8'(i));
    chk("ovf_full", full, 1);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_pre", overflow, 0);
    step(1'b1, 8'hEE);
    chk("ovf_set", overflow, 1);
    chk("ovf_count9", fifo_count, 8);
    mode = RESP;
    drain();
    chk("ovf_last", p_data, 8'h87);
    chk("ovf_sticky", overflow, 1);

    n0 = dv_log.size();
    mode = TMO;
    step(1'b1, 8'hC1);
    step(1'b1, 8'hC2);
    repeat (14) step(1'b0, 8'h00);
    chk("tmo_pulses", dv_log.size() - n0, 2);
    chk("tmo_gap", dv_log.size() >= n0 + 2 ? dv_log[n0+1] - dv_log[n0] : 0, 5);
    chk("tmo_err", tx_err, 1);
    chk("tmo_data", p_data, 8'hC2);
    mode = RESP;

    n0 = dv_log.size();
    for (int i = 0; i < 20; i++) begin
      repeat (($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : 0) step(1'b0, 8'h00);
      step(1'b1, 8'($urandom));
    end
    drain();
    step(1'b1, 8'h3C);
    step(1'b1, 8'h4D);
    n = 0;
    while (expect_dv_at != cyc + 1 && n < 60) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("sync_bound", n < 60, 1);
    pre = q.size();
    step(1'b1, 8'h5E);
    chk("simul_pop", data_valid, 1);
    chk("simul_count", fifo_count, pre);
    drain();

    step(1'b1, 8'h61);
    step(1'b1, 8'h62);
    step(1'b1, 8'h63);
    step(1'b1, 8'h64);
    repeat (2) step(1'b0, 8'h00);
    chk("mid_count", fifo_count, 3);
    chk("mid_busy_seen", tx_busy, 1);
    do_reset();
    n0 = dv_log.size();
    repeat (20) step(1'b0, 8'h00);
    chk("post_rst_pulses", dv_log.size() - n0, 0);
    chk("post_rst_count", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
